md_unit: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers for the E stage of the 5-stage pipeline.
- Generalises the single-cycle ALU path to configurable width and per-operation latency.
- Drives a busy flag that the hazard controller combines with the D-stage instruction to generate enPC/enD/clrE stalls.
- mfhi/mflo read hi/lo directly; mthi/mtlo write through a dedicated port.

---
 rtl/md_pkg.sv | 21 ++
 rtl/md_compute.sv | 58 +++++
 rtl/md_unit.sv | 77 +++++++
 tb/tb_md_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// default latencies and the latency-counter width helper.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic int cnt_width(input int mult_cycles, input int div_cycles);
    int m;
    m = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath on captured operands.
// Produces the HI/LO pair and flags divide-by-zero so the caller can suppress the write.
module md_compute
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0]        prod_u;
  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [WIDTH-1:0]   sa;
  logic signed [WIDTH-1:0]   sb;

  always_comb begin
    sa       = A;
    sb       = B;
    prod_u   = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    prod_s   = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
    res_hi   = '0;
    res_lo   = '0;
    div_zero = 1'b0;
    case (md_op_e'(op))
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        if (B == '0) begin
          div_zero = 1'b1;
        end else if (A == MIN_INT && B == '1) begin
          // Quotient does not fit; wrap to MIN_INT with zero remainder.
          res_lo = MIN_INT;
          res_hi = '0;
        end else begin
          res_lo = sa / sb;
          res_hi = sa % sb;
        end
      end
      MD_DIVU: begin
        if (B == '0) begin
          div_zero = 1'b1;
        end else begin
          res_lo = A / B;
          res_hi = A % B;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Handshake: start is accepted only on an edge where busy=0; busy then stays high for exactly
// the op's latency and falls on the same edge that HI/LO take the result. start while busy is dropped.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_zero;

  md_compute #(.WIDTH(WIDTH)) u_compute (
    .op       (op_q),
    .A        (a_q),
    .B        (b_q),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      busy <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      hi   <= '0;
      lo   <= '0;
    end else if (!busy) begin
      if (start) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= op;
        cnt  <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        busy <= 1'b1;
      end else begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end else begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busy <= 1'b0;
        // Divide by zero burns the full latency but leaves HI/LO untouched.
        if (!div_zero) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed cases plus randomized ops checked against an arithmetic
// model of HI/LO, with an expected-result queue drained at each completion.
module tb_md_unit;
  import md_pkg::*;

  localparam int W  = 32;
  localparam int NM = 5;
  localparam int ND = 10;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks;
  int errors;
  logic [W-1:0]   model_hi;
  logic [W-1:0]   model_lo;
  logic [2*W-1:0] exp_q[$];

  md_unit #(.WIDTH(W), .MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {hi, lo} after an op, from signed/unsigned arithmetic.
  function automatic logic [2*W-1:0] model_result(input logic [1:0] o, input logic [W-1:0] a,
                                                  input logic [W-1:0] b, input logic [2*W-1:0] cur);
    longint sa, sb, qa, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = 64'(sa * sb); return p; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; return p; end
      2'b10: begin
        if (b == 0) return cur;
        qa = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
        q  = ((sa < 0) != (sb < 0)) ? -qa : qa;
        r  = sa - q * sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return cur;
        p[31:0]  = a / b;
        p[63:32] = a - p[31:0] * b;
        return p;
      end
    endcase
  endfunction

  // Driver: launch one op, optionally poke start/lo_we on busy cycle 2, then score.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit inject);
    logic [2*W-1:0] exp_v;
    int n;
    int cyc;
    exp_q.push_back(model_result(o, a, b, {model_hi, model_lo}));
    n = o[1] ? ND : NM;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom_range(0, 3)); A = $urandom; B = $urandom;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      checks++;
      if (hi !== model_hi || lo !== model_lo) begin
        errors++;
        $display("FAIL hold_while_busy cyc=%0d got hi=%h lo=%h want hi=%h lo=%h",
                 cyc, hi, lo, model_hi, model_lo);
      end
      if (inject && cyc == 1) begin
        start = 1'b1; op = MD_DIVU; lo_we = 1'b1; wdata = 32'hAAAA;
      end else if (inject && cyc == 2) begin
        start = 1'b0; lo_we = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; lo_we = 1'b0;
    checks++;
    if (cyc !== n) begin
      errors++;
      $display("FAIL busy_length op=%0d got %0d cycles want %0d", o, cyc, n);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== exp_v) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h",
               o, a, b, hi, lo, exp_v[63:32], exp_v[31:0]);
    end
    {model_hi, model_lo} = exp_v;
  endtask

  task automatic write_hilo(input bit wh, input bit wl, input logic [W-1:0] d);
    @(negedge clk);
    hi_we = wh; lo_we = wl; wdata = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0; wdata = $urandom;
    if (wh) model_hi = d;
    if (wl) model_lo = d;
    checks++;
    if (hi !== model_hi || lo !== model_lo || busy !== 1'b0) begin
      errors++;
      $display("FAIL mt_write got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0",
               hi, lo, busy, model_hi, model_lo);
    end
  endtask

  task automatic check_plan(input string name, input logic [W-1:0] eh, input logic [W-1:0] el);
    checks++;
    if (hi !== eh || lo !== el) begin
      errors++;
      $display("FAIL %s got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, eh, el);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mult();
    do_op(MD_MULT, 32'hFFFFFFFF, 32'h00000002, 1'b0);
    check_plan("mult_plan", 32'hFFFFFFFF, 32'hFFFFFFFE);
    do_op(MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 1'b0);
    check_plan("multu_plan", 32'h00000001, 32'hFFFFFFFE);
  endtask

  task automatic test_div();
    do_op(MD_DIV, 32'hFFFFFFF9, 32'h2, 1'b0);
    check_plan("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op(MD_DIVU, 32'h7, 32'h2, 1'b0);
    check_plan("divu_basic", 32'h1, 32'h3);
    do_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check_plan("div_overflow", 32'h0, 32'h80000000);
  endtask

  task automatic test_div_zero();
    logic [W-1:0] prior_lo;
    write_hilo(1'b1, 1'b0, 32'h1234);
    prior_lo = lo;
    do_op(MD_DIVU, 32'h5, 32'h0, 1'b0);
    check_plan("divu_zero", 32'h1234, prior_lo);
    do_op(MD_DIV, 32'hFFFF0000, 32'h0, 1'b0);
  endtask

  task automatic test_busy_ignore();
    do_op(MD_MULT, 32'h00001234, 32'hFFFFFF00, 1'b1);
    check_plan("ignore_mid_op", 32'hFFFFFFFF, 32'hFFEDCC00);
  endtask

  task automatic test_mid_reset();
    write_hilo(1'b1, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    start = 1'b1; op = MD_MULT; A = 32'h3; B = 32'h7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      errors++;
      $display("FAIL async_reset got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    model_hi = '0; model_lo = '0;
    exp_q.delete();
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      errors++;
      $display("FAIL post_reset_quiet got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'($urandom_range(1, 9));
        2: a = 32'h80000000;
        default: ;
      endcase
      if ($urandom_range(0, 5) == 0) write_hilo(1'($urandom), 1'($urandom), $urandom);
      do_op(o, a, b, 1'b0);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    model_hi = '0; model_lo = '0;
    reset = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_mult();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
